// File: rtl/hamming74_codec.sv
// Hamming(7,4) single-error-correcting codec.
// Encode and decode are independent one-cycle registered paths; the decoder
// also keeps a saturating count of words that arrived with a nonzero syndrome.
// Codeword bit i holds Hamming position i+1: parity at positions 1,2,4 and
// data u[0..3] at positions 3,5,6,7.
module hamming74_codec #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_valid,
  input  logic [3:0]       enc_data,
  output logic             enc_out_valid,
  output logic [6:0]       enc_code,
  input  logic             dec_valid,
  input  logic [6:0]       dec_code,
  output logic             dec_out_valid,
  output logic [2:0]       dec_syndrome,
  output logic [6:0]       dec_corrected,
  output logic [3:0]       dec_data,
  output logic             dec_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);

  logic [6:0] enc_code_c;
  logic [2:0] syn_c;
  logic [6:0] flip_c;
  logic [6:0] corr_c;
  logic [3:0] data_c;
  logic       err_c;

  // Even parity over the data bits that share each parity position's index bit.
  always_comb begin
    enc_code_c    = '0;
    enc_code_c[0] = enc_data[0] ^ enc_data[1] ^ enc_data[3];
    enc_code_c[1] = enc_data[0] ^ enc_data[2] ^ enc_data[3];
    enc_code_c[2] = enc_data[0];
    enc_code_c[3] = enc_data[1] ^ enc_data[2] ^ enc_data[3];
    enc_code_c[4] = enc_data[1];
    enc_code_c[5] = enc_data[2];
    enc_code_c[6] = enc_data[3];
  end

  // Syndrome is the Hamming position of a single flipped bit; every nonzero
  // value names a bit, so correction is unconditional (double errors miscorrect).
  always_comb begin
    syn_c[0] = dec_code[0] ^ dec_code[2] ^ dec_code[4] ^ dec_code[6];
    syn_c[1] = dec_code[1] ^ dec_code[2] ^ dec_code[5] ^ dec_code[6];
    syn_c[2] = dec_code[3] ^ dec_code[4] ^ dec_code[5] ^ dec_code[6];
    err_c    = |syn_c;
    flip_c   = err_c ? (7'd1 << (syn_c - 3'd1)) : 7'd0;
    corr_c   = dec_code ^ flip_c;
    data_c   = {corr_c[6], corr_c[5], corr_c[4], corr_c[2]};
  end

  // Encode path register: data holds when no new nibble arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_out_valid <= 1'b0;
      enc_code      <= '0;
    end else begin
      enc_out_valid <= enc_valid;
      if (enc_valid) enc_code <= enc_code_c;
    end
  end

  // Decode path register: data holds when no new word arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_out_valid <= 1'b0;
      dec_syndrome  <= '0;
      dec_corrected <= '0;
      dec_data      <= '0;
      dec_err       <= 1'b0;
    end else begin
      dec_out_valid <= dec_valid;
      if (dec_valid) begin
        dec_syndrome  <= syn_c;
        dec_corrected <= corr_c;
        dec_data      <= data_c;
        dec_err       <= err_c;
      end
    end
  end

  // Error counter: clear wins over increment; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (dec_valid && err_c && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming74_codec.sv
// Randomized scoreboard bench for hamming74_codec. Expectations are pushed at
// each clock edge from a position-arithmetic reference model; a negedge
// monitor pops them whenever the DUT presents output. A second instance with
// a 2-bit counter shares the stimulus to exercise saturation.
module tb_hamming74_codec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enc_valid = 1'b0;
  logic [3:0]  enc_data = '0;
  logic        dec_valid = 1'b0;
  logic [6:0]  dec_code = '0;
  logic        err_clr = 1'b0;

  logic        enc_out_valid, dec_out_valid, dec_err;
  logic [6:0]  enc_code, dec_corrected;
  logic [2:0]  dec_syndrome;
  logic [3:0]  dec_data;
  logic [15:0] err_count;

  logic        e2_enc_out_valid, e2_dec_out_valid, e2_dec_err;
  logic [6:0]  e2_enc_code, e2_dec_corrected;
  logic [2:0]  e2_dec_syndrome;
  logic [3:0]  e2_dec_data;
  logic [1:0]  e2_err_count;

  hamming74_codec #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .enc_valid(enc_valid), .enc_data(enc_data),
    .enc_out_valid(enc_out_valid), .enc_code(enc_code),
    .dec_valid(dec_valid), .dec_code(dec_code),
    .dec_out_valid(dec_out_valid), .dec_syndrome(dec_syndrome),
    .dec_corrected(dec_corrected), .dec_data(dec_data), .dec_err(dec_err),
    .err_count(err_count), .err_clr(err_clr)
  );

  hamming74_codec #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst),
    .enc_valid(enc_valid), .enc_data(enc_data),
    .enc_out_valid(e2_enc_out_valid), .enc_code(e2_enc_code),
    .dec_valid(dec_valid), .dec_code(dec_code),
    .dec_out_valid(e2_dec_out_valid), .dec_syndrome(e2_dec_syndrome),
    .dec_corrected(e2_dec_corrected), .dec_data(e2_dec_data), .dec_err(e2_dec_err),
    .err_count(e2_err_count), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] syn;
    logic [6:0] corr;
    logic [3:0] data;
    logic       err;
  } dec_exp_t;

  logic [6:0] enc_q[$];
  dec_exp_t   dec_q[$];
  int         exp_cnt16 = 0;
  int         exp_cnt2  = 0;
  logic [6:0] last_enc = '0;
  dec_exp_t   last_dec = '0;
  int         vectors = 0;
  int         miscompares = 0;

  // ---------------- reference model ----------------
  // Syndrome = XOR of the Hamming positions of all set bits.
  function automatic logic [2:0] ref_syn(input logic [6:0] v);
    logic [2:0] s = '0;
    for (int p = 1; p <= 7; p++) if (v[p-1]) s = s ^ 3'(p);
    return s;
  endfunction

  function automatic logic [3:0] data_of(input logic [6:0] v);
    return {v[6], v[5], v[4], v[2]};
  endfunction

  // The codeword is the unique zero-syndrome word carrying u in its data positions.
  function automatic logic [6:0] ref_enc(input logic [3:0] u);
    for (int c = 0; c < 128; c++) begin
      logic [6:0] v;
      v = 7'(c);
      if (ref_syn(v) == 3'd0 && data_of(v) == u) return v;
    end
    return '0;
  endfunction

  function automatic dec_exp_t ref_dec(input logic [6:0] v);
    dec_exp_t r;
    logic [6:0] d;
    r.syn  = ref_syn(v);
    d      = v;
    if (r.syn != 0) d[r.syn - 1] = ~d[r.syn - 1];
    r.corr = d;
    r.data = data_of(d);
    r.err  = (r.syn != 0);
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expectation generator: reacts to inputs seen at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      enc_q.delete();
      dec_q.delete();
      exp_cnt16 = 0;
      exp_cnt2  = 0;
    end else begin
      if (enc_valid) enc_q.push_back(ref_enc(enc_data));
      if (dec_valid) dec_q.push_back(ref_dec(dec_code));
      if (err_clr) begin
        exp_cnt16 = 0;
        exp_cnt2  = 0;
      end else if (dec_valid && ref_syn(dec_code) != 0) begin
        if (exp_cnt16 < 65535) exp_cnt16++;
        if (exp_cnt2 < 3) exp_cnt2++;
      end
    end
  end

  // Monitor: pops on output valid, otherwise checks that data outputs hold.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_enc_out_valid", enc_out_valid, 0);
      chk("rst_enc_code", enc_code, 0);
      chk("rst_dec_out_valid", dec_out_valid, 0);
      chk("rst_dec_syndrome", dec_syndrome, 0);
      chk("rst_dec_corrected", dec_corrected, 0);
      chk("rst_dec_data", dec_data, 0);
      chk("rst_dec_err", dec_err, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_err_count_w2", e2_err_count, 0);
      last_enc = '0;
      last_dec = '0;
    end else begin
      chk("enc_out_valid", enc_out_valid, enc_q.size() != 0);
      if (enc_q.size() != 0) last_enc = enc_q.pop_front();
      chk("enc_code", enc_code, last_enc);
      chk("dec_out_valid", dec_out_valid, dec_q.size() != 0);
      if (dec_q.size() != 0) last_dec = dec_q.pop_front();
      chk("dec_syndrome", dec_syndrome, last_dec.syn);
      chk("dec_corrected", dec_corrected, last_dec.corr);
      chk("dec_data", dec_data, last_dec.data);
      chk("dec_err", dec_err, last_dec.err);
      chk("err_count", err_count, exp_cnt16);
      chk("err_count_w2", e2_err_count, exp_cnt2);
      chk("dec_corrected_w2", e2_dec_corrected, last_dec.corr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic ev, input logic [3:0] ed, input logic dv,
                     input logic [6:0] dc, input logic clr);
    @(posedge clk);
    #1;
    enc_valid = ev;
    enc_data  = ed;
    dec_valid = dv;
    dec_code  = dc;
    err_clr   = clr;
  endtask

  task automatic rand_cyc(input int clr_odds);
    logic [3:0] u;
    logic [6:0] v;
    u = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 1) == 0) v = 7'($urandom_range(0, 127));
    else begin
      v = ref_enc(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) != 0) v[$urandom_range(0, 6)] ^= 1'b1;
    end
    cyc($urandom_range(0, 3) != 0, u, $urandom_range(0, 3) != 0, v,
        $urandom_range(1, clr_odds) == 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Encode sweep plus exhaustive decode: every codeword clean and with each single flip.
    for (int i = 0; i < 128; i++) begin
      logic [6:0] cw;
      int e;
      e  = i % 8;
      cw = ref_enc(4'(i / 8));
      if (e != 7) cw[e] = ~cw[e];
      cyc(1'b1, 4'(i), 1'b1, cw, 1'b0);
    end
    cyc(1'b0, 4'd0, 1'b0, 7'd0, 1'b0);
    chk("sweep_err_count", err_count, 112);
    chk("sweep_err_count_sat_w2", e2_err_count, 3);

    // Clear together with an errored word: clear wins.
    cyc(1'b0, 4'd0, 1'b1, 7'b1000101, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 7'd0, 1'b0);
    chk("clr_priority_count", err_count, 0);
    chk("clr_word_syndrome", dec_syndrome, 3'b101);
    chk("clr_word_corrected", dec_corrected, 7'b1010101);
    chk("clr_word_data", dec_data, 4'b1011);

    // Directed clean known answer.
    cyc(1'b1, 4'b1011, 1'b1, 7'b1010101, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 7'd0, 1'b0);
    chk("ka_enc_1011", enc_code, 7'b1010101);
    chk("ka_clean_syndrome", dec_syndrome, 0);
    chk("ka_clean_err", dec_err, 0);
    chk("ka_clean_data", dec_data, 4'b1011);
    chk("ka_clean_count", err_count, 0);
    repeat (4) cyc(1'b0, 4'd0, 1'b0, 7'd0, 1'b0);

    // Random traffic with gaps and occasional clears.
    for (int i = 0; i < 400; i++) rand_cyc(25);
    repeat (5) cyc(1'b0, 4'd0, 1'b0, 7'd0, 1'b0);

    // Asynchronous reset in the middle of back-to-back traffic.
    for (int i = 0; i < 20; i++) cyc(1'b1, 4'($urandom_range(0, 15)), 1'b1,
                                      7'($urandom_range(0, 127)), 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_enc_out_valid", enc_out_valid, 0);
    chk("async_rst_enc_code", enc_code, 0);
    chk("async_rst_dec_out_valid", dec_out_valid, 0);
    chk("async_rst_dec_corrected", dec_corrected, 0);
    chk("async_rst_err_count", err_count, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 100; i++) rand_cyc(40);

    repeat (3) cyc(1'b0, 4'd0, 1'b0, 7'd0, 1'b0);
    @(negedge clk);
    chk("enc_q_drained", enc_q.size(), 0);
    chk("dec_q_drained", dec_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
